// File: rtl/cdb_arbiter.sv
// Common data bus producer: per-FU result FIFOs drained onto NUM_LANES registered
// CDB lanes by a round-robin arbiter. Flush discards every pending result.
package cdb_pkg;
  localparam int ROB_IDX_LEN    = 5;
  localparam int NUM_CDB_INPUTS = 2;
  localparam int CDB_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      valid;
    logic [ROB_IDX_LEN-1:0]    ROB_dest;
    logic [CDB_DATA_WIDTH-1:0] data;
  } cdb_lane_t;

  typedef cdb_lane_t [NUM_CDB_INPUTS-1:0] common_data_bus_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU     = 4,
  parameter int NUM_LANES  = NUM_CDB_INPUTS,
  parameter int FIFO_DEPTH = 2,
  parameter int WIDTH      = CDB_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [NUM_FU-1:0]      fu_vld_i,
  output logic [NUM_FU-1:0]      fu_rdy_o,
  input  logic [ROB_IDX_LEN-1:0] fu_rob_idx_i [NUM_FU],
  input  logic [WIDTH-1:0]       fu_data_i    [NUM_FU],
  output common_data_bus_t       cdb_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int LW = (NUM_CDB_INPUTS > 1) ? $clog2(NUM_CDB_INPUTS) : 1;

  typedef struct packed {
    logic [ROB_IDX_LEN-1:0] idx;
    logic [WIDTH-1:0]       data;
  } entry_t;

  entry_t           mem_q    [NUM_FU][FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q [NUM_FU];
  logic [PW-1:0]    rd_ptr_q [NUM_FU];
  logic [CW-1:0]    count_q  [NUM_FU];
  logic [CW-1:0]    count_d  [NUM_FU];
  logic [RW-1:0]    rr_ptr_q, rr_ptr_d;
  common_data_bus_t cdb_q, cdb_d;
  logic [NUM_FU-1:0] push, pop;
  logic [RW-1:0]    scan_fu;
  int               n_grant;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready depends only on occupancy, so a pop never raises rdy in the same cycle.
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      fu_rdy_o[k] = !rst && (count_q[k] != CW'(FIFO_DEPTH));
    end
  end

  assign push = fu_vld_i & fu_rdy_o;

  always_comb begin
    pop      = '0;
    cdb_d    = '0;
    rr_ptr_d = rr_ptr_q;
    n_grant  = 0;
    scan_fu  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      scan_fu = RW'((int'(rr_ptr_q) + i) % NUM_FU);
      if (count_q[scan_fu] != '0 && n_grant < NUM_LANES) begin
        pop[scan_fu]                = 1'b1;
        cdb_d[LW'(n_grant)].valid    = 1'b1;
        cdb_d[LW'(n_grant)].ROB_dest = mem_q[scan_fu][rd_ptr_q[scan_fu]].idx;
        cdb_d[LW'(n_grant)].data     = mem_q[scan_fu][rd_ptr_q[scan_fu]].data;
        n_grant                     = n_grant + 1;
        rr_ptr_d                    = RW'((int'(scan_fu) + 1) % NUM_FU);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      count_d[k] = count_q[k] + CW'(push[k]) - CW'(pop[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int k = 0; k < NUM_FU; k++) begin
        count_q[k]  <= '0;
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        count_q[k] <= count_d[k];
        if (push[k]) wr_ptr_q[k] <= ptr_inc(wr_ptr_q[k]);
        if (pop[k])  rd_ptr_q[k] <= ptr_inc(rd_ptr_q[k]);
      end
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_FU; k++) begin
      if (push[k] && !flush_i) begin
        mem_q[k][wr_ptr_q[k]] <= '{idx: fu_rob_idx_i[k], data: fu_data_i[k]};
      end
    end
  end

  assign cdb_o = cdb_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomised bench for cdb_arbiter (4 FUs, 2 lanes, depth 2) with
// a per-FU expected-queue scoreboard that consumes every broadcast lane.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NF = 4;
  localparam int NL = 2;
  localparam int EW = ROB_IDX_LEN + 32;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic [NF-1:0]          vld;
  logic [NF-1:0]          rdy;
  logic [ROB_IDX_LEN-1:0] idx  [NF];
  logic [31:0]            data [NF];
  common_data_bus_t       cdb;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q [NF][$];
  int            wait_c [NF];
  int            bcast  [NF];
  logic [NF-1:0] last_acc;
  logic [2:0]    seq [NF];

  cdb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .fu_vld_i     (vld),
    .fu_rdy_o     (rdy),
    .fu_rob_idx_i (idx),
    .fu_data_i    (data),
    .cdb_o        (cdb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record accepted pushes, step past the edge, then score the lanes.
  task automatic tick();
    logic [NF-1:0] acc, ne, gr;
    logic [EW-1:0] obs;
    logic          drop;
    int            found;
    acc  = vld & rdy;
    drop = flush || rst;
    @(posedge clk);
    #1;
    last_acc = drop ? '0 : acc;
    if (drop) begin
      for (int f = 0; f < NF; f++) begin
        exp_q[f].delete();
        wait_c[f] = 0;
      end
    end else begin
      gr = '0;
      for (int f = 0; f < NF; f++) ne[f] = (exp_q[f].size() != 0);
      for (int l = 0; l < NL; l++) begin
        if (cdb[l].valid) begin
          obs   = {cdb[l].ROB_dest, cdb[l].data};
          found = -1;
          for (int f = 0; f < NF; f++) begin
            if (found < 0 && !gr[f] && exp_q[f].size() != 0 && exp_q[f][0] == obs) found = f;
          end
          chk("sb_lane_expected", 64'(found >= 0), 64'(1));
          if (found >= 0) begin
            void'(exp_q[found].pop_front());
            gr[found] = 1'b1;
            bcast[found]++;
          end
        end
      end
      for (int f = 0; f < NF; f++) begin
        if (acc[f]) exp_q[f].push_back({idx[f], data[f]});
        if (ne[f] && !gr[f]) begin
          wait_c[f]++;
          chk("starvation_bound", 64'(wait_c[f] <= 1), 64'(1));
        end else begin
          wait_c[f] = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = '0;
    tick();
    chk("rst_rdy_low", 64'(rdy), 64'(0));
    chk("rst_cdb_zero", 64'(cdb), 64'(0));
    tick();
    chk("rst_rdy_low2", 64'(rdy), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(rdy), 64'hF);
    chk("post_rst_cdb", 64'(cdb), 64'(0));
  endtask

  task automatic set_fu(input int f, input logic [4:0] i, input logic [31:0] d);
    vld[f]  = 1'b1;
    idx[f]  = i;
    data[f] = d;
  endtask

  initial begin
    int edges, fu1_sent, b1;
    rst   = 1'b1;
    flush = 1'b0;
    vld   = '0;
    for (int f = 0; f < NF; f++) begin
      idx[f] = '0; data[f] = '0; wait_c[f] = 0; bcast[f] = 0; seq[f] = '0;
    end

    // Reset
    do_reset();

    // Contention: all four push together from rr_ptr=0
    for (int f = 0; f < NF; f++) set_fu(f, 5'(10 + f), 32'hA0 + 32'(f));
    tick();
    vld = '0;
    chk("t3_edge_t_lane0", 64'(cdb[0].valid), 64'(0));
    tick();
    chk("t3_t2_lane0", 64'({cdb[0].valid, cdb[0].ROB_dest, cdb[0].data}), {1'b1, 5'd10, 32'hA0});
    chk("t3_t2_lane1", 64'({cdb[1].valid, cdb[1].ROB_dest, cdb[1].data}), {1'b1, 5'd11, 32'hA1});
    chk("t3_t2_rr", 64'(dut.rr_ptr_q), 64'(2));
    tick();
    chk("t3_t3_lane0", 64'({cdb[0].valid, cdb[0].ROB_dest, cdb[0].data}), {1'b1, 5'd12, 32'hA2});
    chk("t3_t3_lane1", 64'({cdb[1].valid, cdb[1].ROB_dest, cdb[1].data}), {1'b1, 5'd13, 32'hA3});
    chk("t3_t3_rr", 64'(dut.rr_ptr_q), 64'(0));
    tick();
    chk("t3_idle", 64'(cdb), 64'(0));

    // Single result from FU2
    set_fu(2, 5'd5, 32'hDEADBEEF);
    tick();
    vld = '0;
    chk("t2_edge_t_lane0", 64'(cdb[0].valid), 64'(0));
    tick();
    chk("t2_lane0", 64'({cdb[0].valid, cdb[0].ROB_dest, cdb[0].data}), {1'b1, 5'd5, 32'hDEADBEEF});
    chk("t2_lane1", 64'(cdb[1]), 64'(0));
    tick();
    chk("t2_gone", 64'(cdb[0].valid), 64'(0));

    // Backpressure: FU1 pushes 4 while all others push every cycle
    do_reset();
    edges = 0;
    fu1_sent = 0;
    b1 = bcast[1];
    while (fu1_sent < 4 && edges < 20) begin
      for (int f = 0; f < NF; f++) set_fu(f, {f[1:0], seq[f]}, 32'hB000_0000 + 32'(f * 256) + 32'(seq[f]));
      tick();
      edges++;
      for (int f = 0; f < NF; f++) if (last_acc[f]) seq[f] = seq[f] + 3'd1;
      if (last_acc[1]) fu1_sent++;
      if (edges == 2) chk("t4_rdy_e2", 64'(rdy), 64'b0011);
      if (edges == 3) chk("t4_rdy_e3", 64'(rdy), 64'b1100);
    end
    chk("t4_fu1_fourth_push_edge", 64'(edges), 64'(5));
    vld = '0;
    for (int c = 0; c < 8; c++) tick();
    chk("t4_fu1_bcast", 64'(bcast[1] - b1), 64'(4));
    for (int f = 0; f < NF; f++) chk("t4_drained", 64'(exp_q[f].size()), 64'(0));

    // Flush with FU3 pushing in the flush cycle
    for (int c = 0; c < 3; c++) begin
      for (int f = 0; f < NF; f++) set_fu(f, {f[1:0], seq[f]}, $urandom);
      tick();
      for (int f = 0; f < NF; f++) if (last_acc[f]) seq[f] = seq[f] + 3'd1;
    end
    vld = '0;
    set_fu(3, 5'd30, 32'h0BAD_F00D);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vld = '0;
    chk("t5_flush_cdb", 64'(cdb), 64'(0));
    chk("t5_flush_rdy", 64'(rdy), 64'hF);
    tick();
    chk("t5_dropped", 64'(cdb), 64'(0));
    set_fu(3, 5'd31, 32'h1234_5678);
    tick();
    vld = '0;
    chk("t5_fresh_early", 64'(cdb[0].valid), 64'(0));
    tick();
    chk("t5_fresh", 64'({cdb[0].valid, cdb[0].ROB_dest, cdb[0].data}), {1'b1, 5'd31, 32'h1234_5678});
    tick();

    // Randomised traffic with occasional flush
    for (int c = 0; c < 10000; c++) begin
      for (int f = 0; f < NF; f++) begin
        vld[f]  = 1'($urandom_range(0, 1));
        idx[f]  = {f[1:0], seq[f]};
        data[f] = $urandom;
      end
      flush = ($urandom_range(0, 199) == 0);
      tick();
      flush = 1'b0;
      for (int f = 0; f < NF; f++) if (last_acc[f]) seq[f] = seq[f] + 3'd1;
    end
    vld = '0;
    for (int c = 0; c < 8; c++) tick();
    for (int f = 0; f < NF; f++) chk("rand_drained", 64'(exp_q[f].size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
